// File: rtl/axi_wroute_pkg.sv
// Shared route-entry type, FSM state type and index widths for the AXI W-channel router.
package axi_wroute_pkg;

    localparam int RT_NUM_M  = 2;
    localparam int RT_NUM_S  = 6;
    localparam int RT_LEN_W  = 4;
    localparam int RT_MIDX_W = (RT_NUM_M > 1) ? $clog2(RT_NUM_M) : 1;
    localparam int RT_SIDX_W = $clog2(RT_NUM_S + 1);

    typedef struct packed {
        logic [RT_MIDX_W-1:0] master;
        logic [RT_SIDX_W-1:0] slave;
        logic [RT_LEN_W-1:0]  len;
    } route_entry_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ROUTE = 1'b1
    } route_state_t;

endpackage

// File: rtl/axi_wroute_fifo.sv
// In-order queue of accepted AW routes; DEPTH must be a power of two so pointers wrap naturally.
module axi_wroute_fifo
    import axi_wroute_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  route_entry_t      i_entry,
    input  logic              i_pop,
    output route_entry_t      o_head,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty
);

    route_entry_t      r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    // Full comes from the registered count only; a same-cycle pop does not make room.
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_entry;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/axi_wdata_router.sv
// AXI W-channel router: steers W beats from NUM_M masters to NUM_S slaves in AW acceptance order.
// Optional AWLEN-based beat counting and WLAST checking: define AXI_WROUTE_LEN_CHECK_EN.
module axi_wdata_router
    import axi_wroute_pkg::*;
#(
    parameter int NUM_M       = RT_NUM_M,
    parameter int NUM_S       = RT_NUM_S,
    parameter int DATA_W      = 32,
    parameter int STRB_W      = DATA_W / 8,
    parameter int ROUTE_DEPTH = 4,
    parameter int LEN_W       = RT_LEN_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         aw_push_i,
    input  logic [$clog2(NUM_M)-1:0]     aw_master_i,
    input  logic [$clog2(NUM_S+1)-1:0]   aw_slave_i,
    input  logic [LEN_W-1:0]             aw_len_i,
    output logic                         aw_full_o,
    input  logic [NUM_M*DATA_W-1:0]      m_wdata_i,
    input  logic [NUM_M*STRB_W-1:0]      m_wstrb_i,
    input  logic [NUM_M-1:0]             m_wlast_i,
    input  logic [NUM_M-1:0]             m_wvalid_i,
    output logic [NUM_M-1:0]             m_wready_o,
    output logic [NUM_S*DATA_W-1:0]      s_wdata_o,
    output logic [NUM_S*STRB_W-1:0]      s_wstrb_o,
    output logic [NUM_S-1:0]             s_wlast_o,
    output logic [NUM_S-1:0]             s_wvalid_o,
    input  logic [NUM_S-1:0]             s_wready_i,
    output logic                         busy_o,
    output logic                         err_o
);

    localparam int MIDX_W = $clog2(NUM_M);
    localparam int SIDX_W = $clog2(NUM_S + 1);
    localparam int CNT_W  = $clog2(ROUTE_DEPTH) + 1;

    route_entry_t        w_push_entry;
    route_entry_t        w_head;
    logic [CNT_W-1:0]    w_count;
    logic                w_full;
    logic                w_empty;
    logic                w_active;
    logic                w_sink;
    logic                w_sready;
    logic                w_head_rdy;
    logic                w_hs;
    logic                w_pop;
    logic                w_len_err;
    logic                w_route_last;
    logic                w_mvalid;
    logic                w_mlast;
    logic [DATA_W-1:0]   w_mdata;
    logic [STRB_W-1:0]   w_mstrb;
    route_state_t        r_state;
    logic                r_err;

    assign w_push_entry = '{master: aw_master_i, slave: aw_slave_i, len: aw_len_i};

    axi_wroute_fifo #(.DEPTH(ROUTE_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (aw_push_i),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_active = (r_state == ST_ROUTE);
    assign w_sink   = (w_head.slave >= SIDX_W'(NUM_S));

    always_comb begin
        w_mvalid = 1'b0;
        w_mlast  = 1'b0;
        w_mdata  = '0;
        w_mstrb  = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (w_head.master == MIDX_W'(i)) begin
                w_mvalid = m_wvalid_i[i];
                w_mlast  = m_wlast_i[i];
                w_mdata  = m_wdata_i[i*DATA_W +: DATA_W];
                w_mstrb  = m_wstrb_i[i*STRB_W +: STRB_W];
            end
        end
    end

    always_comb begin
        w_sready = 1'b0;
        for (int j = 0; j < NUM_S; j++) begin
            if (w_head.slave == SIDX_W'(j)) w_sready = s_wready_i[j];
        end
    end

    // The decode-error sink always accepts, so unmapped bursts drain without a slave.
    assign w_head_rdy = w_sink | w_sready;
    assign w_hs       = w_active & w_mvalid & w_head_rdy;

`ifdef AXI_WROUTE_LEN_CHECK_EN
    logic [LEN_W:0] r_beat;
    logic           w_cnt_last;

    assign w_cnt_last   = (r_beat == {1'b0, w_head.len});
    assign w_route_last = w_cnt_last;
    assign w_pop        = w_hs & w_cnt_last;
    assign w_len_err    = w_hs & (w_mlast != w_cnt_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       r_beat <= '0;
        else if (w_pop) r_beat <= '0;
        else if (w_hs)  r_beat <= r_beat + (LEN_W+1)'(1);
    end
`else
    logic w_unused_len;

    assign w_unused_len = ^w_head.len;
    assign w_route_last = w_mlast;
    assign w_pop        = w_hs & w_mlast;
    assign w_len_err    = 1'b0;
`endif

    always_comb begin
        m_wready_o = '0;
        s_wvalid_o = '0;
        s_wdata_o  = '0;
        s_wstrb_o  = '1;
        s_wlast_o  = '0;
        if (w_active) begin
            for (int i = 0; i < NUM_M; i++) begin
                if (w_head.master == MIDX_W'(i)) m_wready_o[i] = w_head_rdy;
            end
            for (int j = 0; j < NUM_S; j++) begin
                if (w_head.slave == SIDX_W'(j)) begin
                    s_wvalid_o[j]                   = w_mvalid;
                    s_wdata_o[j*DATA_W +: DATA_W]   = w_mdata;
                    s_wstrb_o[j*STRB_W +: STRB_W]   = w_mstrb;
                    s_wlast_o[j]                    = w_route_last;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (aw_push_i) r_state <= ST_ROUTE;
                ST_ROUTE: if (w_pop && !aw_push_i && w_count == CNT_W'(1)) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_err <= 1'b0;
        else      r_err <= r_err | (aw_push_i & w_full) | w_len_err;
    end

    assign aw_full_o = w_full;
    assign busy_o    = ~w_empty;
    assign err_o     = r_err;

endmodule

// File: tb/tb_axi_wdata_router.sv
// Self-checking bench for axi_wdata_router: queue-level reference model plus directed scenarios.
// Scenario with WLAST disagreement runs only when AXI_WROUTE_LEN_CHECK_EN is defined.
module tb_axi_wdata_router;

    localparam int NUM_M = 2;
    localparam int NUM_S = 6;
    localparam int DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 aw_push_i = 1'b0;
    logic [0:0]           aw_master_i = '0;
    logic [2:0]           aw_slave_i = '0;
    logic [3:0]           aw_len_i = '0;
    logic                 aw_full_o;
    logic [NUM_M*32-1:0]  m_wdata_i = '0;
    logic [NUM_M*4-1:0]   m_wstrb_i = '0;
    logic [NUM_M-1:0]     m_wlast_i = '0;
    logic [NUM_M-1:0]     m_wvalid_i = '0;
    logic [NUM_M-1:0]     m_wready_o;
    logic [NUM_S*32-1:0]  s_wdata_o;
    logic [NUM_S*4-1:0]   s_wstrb_o;
    logic [NUM_S-1:0]     s_wlast_o;
    logic [NUM_S-1:0]     s_wvalid_o;
    logic [NUM_S-1:0]     s_wready_i = '1;
    logic                 busy_o;
    logic                 err_o;

    axi_wdata_router dut (
        .clk(clk), .rst(rst),
        .aw_push_i(aw_push_i), .aw_master_i(aw_master_i), .aw_slave_i(aw_slave_i),
        .aw_len_i(aw_len_i), .aw_full_o(aw_full_o),
        .m_wdata_i(m_wdata_i), .m_wstrb_i(m_wstrb_i), .m_wlast_i(m_wlast_i),
        .m_wvalid_i(m_wvalid_i), .m_wready_o(m_wready_o),
        .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o), .s_wlast_o(s_wlast_o),
        .s_wvalid_o(s_wvalid_o), .s_wready_i(s_wready_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of accepted routes plus a beat count of the head burst.
    typedef struct { int m; int s; int len; } ent_t;
    ent_t q[$];
    int   mb = 0;
    bit   merr = 1'b0;
    int   um, us;
    bit   uhs, upop, ulc, ufull;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            mb = 0;
            merr = 1'b0;
        end else begin
            ufull = (q.size() == DEPTH);
            upop = 1'b0;
            if (q.size() > 0) begin
                um  = q[0].m;
                us  = q[0].s;
                uhs = m_wvalid_i[um] && ((us >= NUM_S) ? 1'b1 : s_wready_i[us]);
`ifdef AXI_WROUTE_LEN_CHECK_EN
                ulc  = (mb == q[0].len);
                upop = uhs && ulc;
                if (uhs && (m_wlast_i[um] != ulc)) merr = 1'b1;
                if (uhs) mb = upop ? 0 : mb + 1;
`else
                upop = uhs && m_wlast_i[um];
`endif
            end
            if (upop) q.delete(0);
            if (aw_push_i) begin
                if (ufull) merr = 1'b1;
                else q.push_back('{int'(aw_master_i), int'(aw_slave_i), int'(aw_len_i)});
            end
        end
    end

    logic [NUM_M-1:0]    e_mr;
    logic [NUM_S-1:0]    e_sv, e_sl;
    logic [NUM_S*32-1:0] e_sd;
    logic [NUM_S*4-1:0]  e_ss;
    int                  cm, cs;

    always @(negedge clk) begin
        e_mr = '0; e_sv = '0; e_sd = '0; e_ss = '1; e_sl = '0;
        if (rst && q.size() > 0) begin
            cm = q[0].m;
            cs = q[0].s;
            e_mr[cm] = (cs >= NUM_S) ? 1'b1 : s_wready_i[cs];
            if (cs < NUM_S) begin
                e_sv[cs]         = m_wvalid_i[cm];
                e_sd[cs*32 +: 32] = m_wdata_i[cm*32 +: 32];
                e_ss[cs*4 +: 4]   = m_wstrb_i[cm*4 +: 4];
`ifdef AXI_WROUTE_LEN_CHECK_EN
                e_sl[cs] = (mb == q[0].len);
`else
                e_sl[cs] = m_wlast_i[cm];
`endif
            end
        end
        chk("m_wready", m_wready_o, e_mr);
        chk("s_wvalid", s_wvalid_o, e_sv);
        chk("s_wdata", s_wdata_o, e_sd);
        chk("s_wstrb", s_wstrb_o, e_ss);
        chk("s_wlast", s_wlast_o, e_sl);
        chk("aw_full", aw_full_o, q.size() == DEPTH);
        chk("busy", busy_o, q.size() != 0);
        chk("err", err_o, merr);
    end

    // Master stimulus: per-master queue of burst lengths (beats-1) and current beat.
    int bq0[$], bq1[$];
    int bc0 = 0, bc1 = 0;
    int bad0 = -1, bad1 = -1;
    logic [31:0] dbase0 = 32'hA0A0_0000, dbase1 = 32'hB1B1_0000;
    logic [3:0]  sbase0 = 4'hF, sbase1 = 4'hC;
    logic [NUM_M-1:0] hs;

    task automatic drive();
        m_wvalid_i[0]  = (bq0.size() > 0);
        m_wdata_i[31:0] = dbase0 + 32'(bc0);
        m_wstrb_i[3:0]  = sbase0;
        m_wlast_i[0]   = (bq0.size() > 0) && ((bad0 >= 0) ? (bc0 == bad0) : (bc0 == bq0[0]));
        m_wvalid_i[1]  = (bq1.size() > 0);
        m_wdata_i[63:32] = dbase1 + 32'(bc1);
        m_wstrb_i[7:4]   = sbase1;
        m_wlast_i[1]   = (bq1.size() > 0) && ((bad1 >= 0) ? (bc1 == bad1) : (bc1 == bq1[0]));
    endtask

    task automatic sample();
        @(negedge clk); #1;
        hs = m_wvalid_i & m_wready_o;
    endtask

    task automatic advance();
        @(posedge clk); #1;
        aw_push_i = 1'b0;
        if (hs[0]) begin
            if (bc0 == bq0[0]) begin bq0.delete(0); bc0 = 0; end
            else bc0++;
        end
        if (hs[1]) begin
            if (bc1 == bq1[0]) begin bq1.delete(0); bc1 = 0; end
            else bc1++;
        end
        drive();
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic push(input int m, input int s, input int l);
        aw_push_i   = 1'b1;
        aw_master_i = 1'(m);
        aw_slave_i  = 3'(s);
        aw_len_i    = 4'(l);
        cyc();
    endtask

    task automatic run_idle(input string nm);
        int k;
        k = 0;
        while ((bq0.size() > 0 || bq1.size() > 0 || busy_o) && k < 200) begin
            cyc();
            k++;
        end
        n_vec++;
        if (k >= 200) begin
            n_err++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", nm, k);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bq0.delete(); bq1.delete(); bc0 = 0; bc1 = 0;
        drive();
        sample();
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_strb", s_wstrb_o, 24'hFFFFFF);
        chk("rst_wready", m_wready_o, 2'b00);
        chk("rst_svalid", s_wvalid_o, 6'b0);
        advance();
        rst = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        drive();
        repeat (2) cyc();
        do_reset();
        cyc();

        // Single-beat burst M1 -> S2
        dbase1 = 32'hDEADBEEF; sbase1 = 4'h3;
        bq1.push_back(0);
        drive();
        aw_push_i = 1'b1; aw_master_i = 1'b1; aw_slave_i = 3'd2; aw_len_i = 4'd0;
        sample();
        chk("t1_pre_svalid", s_wvalid_o, 6'b0);
        chk("t1_pre_wready", m_wready_o, 2'b00);
        advance();
        sample();
        chk("t1_svalid", s_wvalid_o, 6'b000100);
        chk("t1_sdata", s_wdata_o[95:64], 32'hDEADBEEF);
        chk("t1_sstrb", s_wstrb_o[11:8], 4'h3);
        chk("t1_slast", s_wlast_o[2], 1'b1);
        chk("t1_wready", m_wready_o, 2'b10);
        advance();
        sample();
        chk("t1_busy_after", busy_o, 1'b0);
        advance();
        dbase1 = 32'hB1B1_0000; sbase1 = 4'hC;

        // Two outstanding 4-beat bursts, M1 valid early, with a slave stall
        bq0.push_back(3); bq1.push_back(3);
        drive();
        push(0, 5, 3);
        push(1, 3, 3);
        s_wready_i[5] = 1'b0;
        sample();
        chk("t2_stall_wready", m_wready_o, 2'b00);
        advance();
        cyc();
        s_wready_i[5] = 1'b1;
        for (int k = 0; k < 20 && bq0.size() > 0; k++) begin
            sample();
            chk("t2_m1_blocked", m_wready_o[1], 1'b0);
            advance();
        end
        sample();
        chk("t2_m1_wready", m_wready_o, 2'b10);
        chk("t2_s3_valid", s_wvalid_o, 6'b001000);
        advance();
        run_idle("t2");

        // Queue full and overflow
        for (int j = 0; j < DEPTH; j++) push(0, j, 0);
        aw_push_i = 1'b1; aw_master_i = 1'b1; aw_slave_i = 3'd4; aw_len_i = 4'd0;
        sample();
        chk("t3_full", aw_full_o, 1'b1);
        chk("t3_err_before", err_o, 1'b0);
        advance();
        sample();
        chk("t3_err_after", err_o, 1'b1);
        chk("t3_full_after", aw_full_o, 1'b1);
        advance();
        for (int j = 0; j < DEPTH; j++) bq0.push_back(0);
        drive();
        run_idle("t3");
        chk("t3_drained", busy_o, 1'b0);
        do_reset();

        // Decode-error sink, 2 beats
        bq0.push_back(1);
        drive();
        push(0, NUM_S, 1);
        for (int k = 0; k < 2; k++) begin
            sample();
            chk("t4_wready", m_wready_o, 2'b01);
            chk("t4_svalid", s_wvalid_o, 6'b0);
            chk("t4_sdata", s_wdata_o, 192'b0);
            advance();
        end
        sample();
        chk("t4_busy_after", busy_o, 1'b0);
        advance();

        // Reset in the middle of a 4-beat burst
        bq0.push_back(3);
        drive();
        push(0, 1, 3);
        cyc();
        cyc();
        do_reset();
        bq0.push_back(0);
        drive();
        sample();
        chk("t5_no_stale", m_wready_o, 2'b00);
        chk("t5_busy", busy_o, 1'b0);
        advance();
        push(0, 0, 0);
        run_idle("t5");

`ifdef AXI_WROUTE_LEN_CHECK_EN
        // WLAST on beat 2 of a 4-beat burst
        bad1 = 1;
        bq1.push_back(3);
        drive();
        push(1, 4, 3);
        sample();
        chk("t6_err_beat1", err_o, 1'b0);
        chk("t6_last_beat1", s_wlast_o[4], 1'b0);
        advance();
        sample();
        chk("t6_last_beat2", s_wlast_o[4], 1'b0);
        advance();
        sample();
        chk("t6_err_beat3", err_o, 1'b1);
        advance();
        sample();
        chk("t6_last_beat4", s_wlast_o[4], 1'b1);
        chk("t6_busy_beat4", busy_o, 1'b1);
        advance();
        sample();
        chk("t6_busy_after", busy_o, 1'b0);
        advance();
        bad1 = -1;
`endif

        repeat (2) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
